// File: rtl/rcv_len_ctrl.sv
// Receive-length controller: loads a byte count, consumes BEAT_BYTES per accepted beat and
// reports last beat, byte enables, completion, beat count and overflow status.
module rcv_len_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned BEAT_BYTES = 4,
  parameter int unsigned NXT_N      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      wr_size,
  input  logic [CNT_W-1:0]      bc_size,
  input  logic                  rcv_wr_d,
  input  logic                  rcv_bc_d,
  input  logic                  rcv_clr,
  input  logic [NXT_N-1:0]      rcv_nxt,
  output logic [CNT_W-1:0]      rcv_size,
  output logic                  rcv_last,
  output logic                  rcv_done,
  output logic                  rcv_done_p,
  output logic [BEAT_BYTES-1:0] rcv_be,
  output logic                  rcv_busy,
  output logic                  rcv_ovf,
  output logic [CNT_W-1:0]      rcv_beats
);

  localparam logic [CNT_W-1:0] BeatSize = CNT_W'(BEAT_BYTES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] size_q, size_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] load_val;
  logic             ovf_q, ovf_d;
  logic             done_p_q, done_p_d;
  logic             beat;

  assign beat       = |rcv_nxt;
  assign rcv_size   = size_q;
  assign rcv_last   = (size_q <= BeatSize);
  assign rcv_done   = (size_q == '0);
  assign rcv_done_p = done_p_q;
  assign rcv_busy   = (state_q == StRun);
  assign rcv_ovf    = ovf_q;
  assign rcv_beats  = beats_q;

  // Byte lane i is live while more than i bytes remain; saturates to all ones.
  always_comb begin
    rcv_be = '0;
    for (int unsigned i = 0; i < BEAT_BYTES; i++) begin
      rcv_be[i] = (size_q > CNT_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    beats_d  = beats_q;
    ovf_d    = ovf_q;
    done_p_d = 1'b0;
    load_val = rcv_wr_d ? wr_size : bc_size;

    if (rcv_clr) begin
      state_d = StIdle;
      size_d  = '0;
      beats_d = '0;
      ovf_d   = 1'b0;
    end else if (rcv_wr_d || rcv_bc_d) begin
      // A beat coinciding with a load is dropped silently.
      size_d  = load_val;
      beats_d = '0;
      state_d = (load_val != '0) ? StRun : StIdle;
    end else if (beat) begin
      unique case (state_q)
        StRun: begin
          beats_d = (beats_q != '1) ? beats_q + CNT_W'(1) : beats_q;
          if (rcv_last) begin
            size_d   = '0;
            state_d  = StDone;
            done_p_d = 1'b1;
          end else begin
            size_d = size_q - BeatSize;
          end
        end
        StIdle, StDone: ovf_d = 1'b1;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      size_q   <= '0;
      beats_q  <= '0;
      ovf_q    <= 1'b0;
      done_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      beats_q  <= beats_d;
      ovf_q    <= ovf_d;
      done_p_q <= done_p_d;
    end
  end

endmodule

// File: tb/tb_rcv_len_ctrl.sv
// Scoreboard bench for rcv_len_ctrl: two instances (4-byte and 1-byte beats) share stimulus
// and are compared against a model tracking loaded length and accepted beat count.
module tb_rcv_len_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_size, bc_size;
  logic        rcv_wr_d, rcv_bc_d, rcv_clr;
  logic [2:0]  rcv_nxt;

  logic [15:0] a_size, a_beats, b_size, b_beats;
  logic        a_last, a_done, a_done_p, a_busy, a_ovf;
  logic        b_last, b_done, b_done_p, b_busy, b_ovf;
  logic [3:0]  a_be;
  logic [0:0]  b_be;

  always #5 clk = ~clk;

  rcv_len_ctrl #(.CNT_W(16), .BEAT_BYTES(4), .NXT_N(3)) dut4 (
    .clk(clk), .rst(rst), .wr_size(wr_size), .bc_size(bc_size), .rcv_wr_d(rcv_wr_d),
    .rcv_bc_d(rcv_bc_d), .rcv_clr(rcv_clr), .rcv_nxt(rcv_nxt), .rcv_size(a_size),
    .rcv_last(a_last), .rcv_done(a_done), .rcv_done_p(a_done_p), .rcv_be(a_be),
    .rcv_busy(a_busy), .rcv_ovf(a_ovf), .rcv_beats(a_beats)
  );

  rcv_len_ctrl #(.CNT_W(16), .BEAT_BYTES(1), .NXT_N(3)) dut1 (
    .clk(clk), .rst(rst), .wr_size(wr_size), .bc_size(bc_size), .rcv_wr_d(rcv_wr_d),
    .rcv_bc_d(rcv_bc_d), .rcv_clr(rcv_clr), .rcv_nxt(rcv_nxt), .rcv_size(b_size),
    .rcv_last(b_last), .rcv_done(b_done), .rcv_done_p(b_done_p), .rcv_be(b_be),
    .rcv_busy(b_busy), .rcv_ovf(b_ovf), .rcv_beats(b_beats)
  );

  // Model: remaining bytes = loaded length minus bytes consumed by accepted beats.
  typedef struct { longint len; longint n; bit ovf; bit pulse; } mdl_t;
  typedef struct { longint size; bit last, done, pulse, busy, ovf; longint be, beats; } exp_t;
  typedef struct { exp_t a; exp_t b; } pair_t;

  mdl_t  m4, m1;
  pair_t sb_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic longint rem_of(mdl_t m, int bb);
    longint t = m.len - m.n * bb;
    return (t > 0) ? t : 0;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.len = 0; m.n = 0; m.ovf = 0; m.pulse = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int bb, bit c, bit w, bit b, bit beat,
                                 longint ws, longint bs);
    bit running = (m.len != 0) && (rem_of(m, bb) > 0);
    m.pulse = 0;
    if (c) begin
      m.len = 0; m.n = 0; m.ovf = 0;
    end else if (w) begin
      m.len = ws; m.n = 0;
    end else if (b) begin
      m.len = bs; m.n = 0;
    end else if (beat) begin
      if (running) begin
        m.n++;
        if (rem_of(m, bb) == 0) m.pulse = 1;
      end else begin
        m.ovf = 1;
      end
    end
    return m;
  endfunction

  function automatic exp_t expect_of(mdl_t m, int bb);
    exp_t   e;
    longint r = rem_of(m, bb);
    e.size  = r;
    e.last  = (r <= bb);
    e.done  = (r == 0);
    e.pulse = m.pulse;
    e.busy  = (m.len != 0) && (r > 0);
    e.ovf   = m.ovf;
    e.be    = (r >= bb) ? ((longint'(1) << bb) - 1) : ((longint'(1) << r) - 1);
    e.beats = (m.n > 65535) ? 65535 : m.n;
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of stimulus; push the expectation for the currently visible state.
  task automatic cyc(input bit r, input bit c, input bit w, input bit b, input logic [2:0] nx,
                     input logic [15:0] ws, input logic [15:0] bs);
    pair_t p;
    @(posedge clk);
    #1;
    rst = r; rcv_clr = c; rcv_wr_d = w; rcv_bc_d = b; rcv_nxt = nx;
    wr_size = ws; bc_size = bs;
    if (r) begin
      m4 = mreset();
      m1 = mreset();
    end
    p.a = expect_of(m4, 4);
    p.b = expect_of(m1, 1);
    sb_q.push_back(p);
    if (!r) begin
      m4 = mstep(m4, 4, c, w, b, |nx, longint'(ws), longint'(bs));
      m1 = mstep(m1, 1, c, w, b, |nx, longint'(ws), longint'(bs));
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 3'b000, 16'd0, 16'd0);
  endtask

  task automatic beat(input logic [2:0] nx);
    cyc(0, 0, 0, 0, nx, 16'd0, 16'd0);
  endtask

  initial begin : monitor
    pair_t p;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        p = sb_q.pop_front();
        chk("a_size",   a_size,   p.a.size);
        chk("a_last",   a_last,   p.a.last);
        chk("a_done",   a_done,   p.a.done);
        chk("a_done_p", a_done_p, p.a.pulse);
        chk("a_be",     a_be,     p.a.be);
        chk("a_busy",   a_busy,   p.a.busy);
        chk("a_ovf",    a_ovf,    p.a.ovf);
        chk("a_beats",  a_beats,  p.a.beats);
        chk("b_size",   b_size,   p.b.size);
        chk("b_last",   b_last,   p.b.last);
        chk("b_done",   b_done,   p.b.done);
        chk("b_done_p", b_done_p, p.b.pulse);
        chk("b_be",     b_be,     p.b.be);
        chk("b_busy",   b_busy,   p.b.busy);
        chk("b_ovf",    b_ovf,    p.b.ovf);
        chk("b_beats",  b_beats,  p.b.beats);
      end
    end
  end

  initial begin : driver
    rst = 1'b1; rcv_clr = 0; rcv_wr_d = 0; rcv_bc_d = 0; rcv_nxt = 0;
    wr_size = 0; bc_size = 0;
    m4 = mreset();
    m1 = mreset();
    cyc(1, 0, 0, 0, 3'b000, 16'd0, 16'd0);
    cyc(1, 0, 0, 0, 3'b000, 16'd0, 16'd0);
    idle(2);

    // Write load of 10 bytes, three beats.
    cyc(0, 0, 1, 0, 3'b000, 16'd10, 16'd0);
    repeat (3) beat(3'b001);
    idle(2);

    // Broadcast load of 8, beats on alternating request bits.
    cyc(0, 0, 0, 1, 3'b000, 16'd0, 16'd8);
    beat(3'b010);
    beat(3'b100);
    idle(2);

    // Overflow after completion, then clear.
    beat(3'b001);
    idle(1);
    cyc(0, 1, 0, 0, 3'b000, 16'd0, 16'd0);
    idle(1);

    // Priority collisions.
    cyc(0, 1, 1, 0, 3'b001, 16'd20, 16'd0);
    idle(1);
    cyc(0, 0, 1, 1, 3'b111, 16'd20, 16'd40);
    idle(2);
    cyc(0, 1, 0, 0, 3'b000, 16'd0, 16'd0);

    // Zero-length load, then a stray beat.
    cyc(0, 0, 1, 0, 3'b000, 16'd0, 16'd0);
    idle(1);
    beat(3'b001);
    idle(1);
    cyc(0, 1, 0, 0, 3'b000, 16'd0, 16'd0);

    // Long transfer aborted by reset at size 0x7FF3 on the 4-byte instance.
    cyc(0, 0, 1, 0, 3'b000, 16'hFFFF, 16'd0);
    repeat (8195) beat(3'b001);
    idle(1);
    cyc(1, 0, 0, 0, 3'b000, 16'd0, 16'd0);
    cyc(1, 0, 0, 0, 3'b000, 16'd0, 16'd0);
    idle(2);

    // Short transfer exercising the 1-byte instance.
    cyc(0, 0, 1, 0, 3'b000, 16'd3, 16'd0);
    repeat (3) beat(3'b001);
    idle(2);
    cyc(0, 1, 0, 0, 3'b000, 16'd0, 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, c, w, b;
      logic [2:0]  nx;
      logic [15:0] ws, bs;
      r  = ($urandom_range(0, 499) == 0);
      c  = ($urandom_range(0, 99) < 3);
      w  = ($urandom_range(0, 99) < 6);
      b  = ($urandom_range(0, 99) < 4);
      nx = ($urandom_range(0, 99) < 60) ? 3'($urandom_range(1, 7)) : 3'b000;
      ws = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      bs = 16'($urandom_range(0, 40));
      cyc(r, c, w, b, nx, ws, bs);
    end
    idle(3);

    repeat (3) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rcv_len_ctrl.md
Name: rcv_len_ctrl

Overview:
Parametrised receive-length controller for the SPI slave datapath. It loads a transfer byte count from either the write-size or the broadcast-extend field. It decrements the count by one beat's worth of bytes on each accepted receive beat. It reports the last beat, per-beat byte enables, completion, beat count and protocol-error status to the receive FIFO and the command FSM.

Parameters:
CNT_W, 16, width of byte counters and size inputs
BEAT_BYTES, 4, bytes consumed per beat; power of two, 1 to 2^(CNT_W-1)
NXT_N, 3, number of beat-request sources, OR-combined

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
wr_size  input  CNT_W  byte count for write transfers
bc_size  input  CNT_W  byte count for broadcast/extended transfers
rcv_wr_d  input  1  load wr_size (single-cycle strobe)
rcv_bc_d  input  1  load bc_size (single-cycle strobe)
rcv_clr  input  1  synchronous clear of count, state and error
rcv_nxt  input  NXT_N  beat requests; any bit set = one beat this cycle
rcv_size  output  CNT_W  remaining byte count (registered)
rcv_last  output  1  current beat is the final one
rcv_done  output  1  rcv_size == 0
rcv_done_p  output  1  one-cycle pulse on completion
rcv_be  output  BEAT_BYTES  byte enables for current beat, LSB = first byte
rcv_busy  output  1  state == RUN
rcv_ovf  output  1  sticky: beat requested while not in RUN
rcv_beats  output  CNT_W  beats accepted since last load or clear, saturating

Behaviour:
- Reset (async, rst=1): rcv_size=0, state=IDLE, rcv_done_p=0, rcv_ovf=0, rcv_beats=0. Combinational outputs follow from these: rcv_done=1, rcv_last=1, rcv_be=0, rcv_busy=0.
- beat = |rcv_nxt.
- Priority per cycle: rcv_clr > rcv_wr_d > rcv_bc_d > beat.
- rcv_clr: rcv_size=0, state=IDLE, rcv_ovf=0, rcv_beats=0, rcv_done_p=0.
- Load (wr or bc): rcv_size=selected value, rcv_beats=0. State=RUN if value≠0, else IDLE with no done pulse. A beat in the same cycle is dropped: not counted and not flagged as an error.
- States: IDLE, RUN, DONE.
  - IDLE: beat sets rcv_ovf; a nonzero load goes to RUN.
  - RUN: on a beat, rcv_size takes the next value (below) and rcv_beats increments, saturating at 2^CNT_W-1. If rcv_last, go to DONE with rcv_size=0 and assert rcv_done_p for exactly the next cycle.
  - DONE: beat sets rcv_ovf and leaves rcv_size at 0. A load goes to RUN or IDLE by value; rcv_clr goes to IDLE.
- Next size on a beat: 0 if rcv_last, else rcv_size - BEAT_BYTES. No wrap below 0 is possible.
- rcv_last = (rcv_size <= BEAT_BYTES), combinational. It is also 1 at size 0, matching the legacy counter.
- rcv_done = (rcv_size == 0), combinational.
- rcv_be, combinational:
  - all ones if rcv_size >= BEAT_BYTES;
  - otherwise the low rcv_size bits set;
  - 0 when rcv_size == 0.
- Counter states are registered, with no latency beyond one clock. rcv_size reflects a beat on the cycle after the request.
- Reset mid-transfer aborts immediately. No pulse is generated.
- BEAT_BYTES=1: rcv_last only at size ≤1; rcv_be is always 1 while size≠0.

Test Plan:
- Load wr_size=10, three beats on rcv_nxt[0] -> rcv_size 10,6,2,0; rcv_be 1111,1111,0011; rcv_last only at size 2; rcv_done_p one cycle after the third beat; rcv_beats=3; state DONE.
- Load bc_size=8, beats alternating on rcv_nxt[1]/rcv_nxt[2] -> 8,4,0; rcv_be 1111 on both beats; rcv_done_p once; no rcv_ovf.
- After DONE, one extra beat -> rcv_ovf=1 sticky, rcv_size stays 0. rcv_clr -> rcv_ovf=0, rcv_beats=0, state IDLE.
- Same cycle: rcv_clr, rcv_wr_d=20 and beat -> rcv_size=0, IDLE. Same cycle: rcv_wr_d=20, rcv_bc_d=40 and beat -> rcv_size=20, rcv_beats=0, no rcv_ovf.
- Load wr_size=0 -> IDLE, rcv_done=1, no rcv_done_p. A following beat -> rcv_ovf=1.
- Load 0xFFFF with CNT_W=16, issue beats, assert rst mid-transfer at size 0x7FF3 -> all outputs at reset values immediately; no rcv_done_p. Repeat the run with BEAT_BYTES=1 and size 3 -> rcv_size 3,2,1,0; rcv_be 1,1,1.
